cbus_sram_responder: RTL

Worker-side endpoint of the cache bus (`cbus_req_t` / `cbus_resp_t`). It accepts burst transactions from a cache or cache-bus arbiter and serves them from an internal 64-bit-wide SRAM, driving per-beat `ready`/`last`/`data`. It replaces the AXI memory path in unit-level cache benches and small FPGA builds. It supports FIXED, INCR and WRAP bursts with byte strobes.

---
 rtl/common.sv | 50 +++++
 rtl/cbus_addr_gen.sv | 35 +++
 rtl/cbus_sram_responder.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/common.sv
// ---------------------------------------------------------------------------
// common
// Shared cache-bus definitions: request/response structs, burst length and
// burst type encodings, the SRAM responder state type and the beat width.
// No ports (package).
// ---------------------------------------------------------------------------
package common;

  localparam int CBUS_BEAT_BYTES = 8;

  // Encoded as (number of beats - 1).
  typedef enum logic [3:0] {
    MLEN1  = 4'd0,
    MLEN2  = 4'd1,
    MLEN4  = 4'd3,
    MLEN8  = 4'd7,
    MLEN16 = 4'd15
  } mlen_t;

  typedef enum logic [1:0] {
    AXI_BURST_FIXED    = 2'd0,
    AXI_BURST_INCR     = 2'd1,
    AXI_BURST_WRAP     = 2'd2,
    AXI_BURST_RESERVED = 2'd3
  } axi_burst_type_t;

  typedef struct packed {
    logic            valid;
    logic            is_write;
    logic [63:0]     addr;
    logic [2:0]      size;
    mlen_t           len;
    axi_burst_type_t burst;
    logic [63:0]     data;
    logic [7:0]      strobe;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    BURST = 2'd2
  } cbus_resp_state_t;

endpackage

// File: rtl/cbus_addr_gen.sv
// ---------------------------------------------------------------------------
// cbus_addr_gen
// Combinational next-beat address for cache-bus bursts (8-byte beats).
//   addr      in  : current beat byte address
//   len       in  : burst length (beats - 1)
//   burst     in  : FIXED / INCR / WRAP / RESERVED
//   next_addr out : address of the following beat
// ---------------------------------------------------------------------------
module cbus_addr_gen
  import common::*;
(
  input  logic [63:0]     addr,
  input  mlen_t           len,
  input  axi_burst_type_t burst,
  output logic [63:0]     next_addr
);

  logic [63:0] step_addr;
  logic [63:0] wrap_mask;

  // Burst byte span is (len+1)*8, a power of two for every legal len, so the
  // wrap mask is simply len shifted over the beat offset bits.
  assign step_addr = addr + 64'(CBUS_BEAT_BYTES);
  assign wrap_mask = {57'd0, len, 3'b111};

  always_comb begin
    next_addr = step_addr;
    case (burst)
      AXI_BURST_FIXED: next_addr = addr;
      AXI_BURST_WRAP:  next_addr = (addr & ~wrap_mask) | (step_addr & wrap_mask);
      default:         next_addr = step_addr;
    endcase
  end

endmodule

// File: rtl/cbus_sram_responder.sv
// ---------------------------------------------------------------------------
// cbus_sram_responder
// Cache-bus worker endpoint serving FIXED/INCR/WRAP bursts from an internal
// 64-bit-wide SRAM with byte-strobed writes.
//   clk    in  : clock, all state changes on posedge
//   resetn in  : asynchronous active-low reset
//   creq   in  : cache-bus request (held stable by the master for the burst)
//   cresp  out : per-beat ready/last/data
// Optional feature macro: CBUS_WAIT_STATE_EN inserts WAIT_CYCLES idle cycles
// between request acceptance and the first beat.
// ---------------------------------------------------------------------------
module cbus_sram_responder
  import common::*;
#(
  parameter int unsigned MEM_BYTES   = 65536,
  parameter logic [63:0] BASE_ADDR   = 64'h0000_0000_8000_0000,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  cbus_req_t  creq,
  output cbus_resp_t cresp
);

  localparam int unsigned MEM_WORDS = MEM_BYTES / CBUS_BEAT_BYTES;
  localparam int unsigned IDX_W     = $clog2(MEM_WORDS);

`ifdef CBUS_WAIT_STATE_EN
  localparam cbus_resp_state_t FIRST_STATE = (WAIT_CYCLES > 0) ? WAIT : BURST;
`else
  localparam cbus_resp_state_t FIRST_STATE = BURST;
`endif

  cbus_resp_state_t state_q, state_d;
  logic [63:0]      addr_q;
  mlen_t            len_q;
  axi_burst_type_t  burst_q;
  logic             write_q;
  logic [3:0]       beat_cnt;
  logic [63:0]      next_addr;
  logic             last_beat;

  logic [63:0]      word_off;
  logic             in_range;
  logic [IDX_W-1:0] word_idx;

  logic [63:0]      mem [MEM_WORDS];

`ifdef CBUS_WAIT_STATE_EN
  logic [31:0]      wait_cnt;
  logic             wait_done;
  assign wait_done = (wait_cnt == 32'(WAIT_CYCLES - 1));
`else
  logic             unused_wait_cfg;
  assign unused_wait_cfg = (WAIT_CYCLES != 0);
`endif

  // The transfer size never affects stepping: every beat is a full word.
  logic unused_size;
  assign unused_size = ^creq.size;

  cbus_addr_gen u_addr_gen (
    .addr      (addr_q),
    .len       (len_q),
    .burst     (burst_q),
    .next_addr (next_addr)
  );

  assign last_beat = (beat_cnt == 4'(len_q));

  // addr < BASE_ADDR wraps word_off to a huge value, but the explicit lower
  // bound keeps the range test honest regardless of BASE_ADDR.
  assign word_off = addr_q - BASE_ADDR;
  assign in_range = (addr_q >= BASE_ADDR) && (word_off < 64'(MEM_BYTES));
  assign word_idx = word_off[IDX_W+2:3];

  // State and burst context registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      len_q    <= MLEN1;
      burst_q  <= AXI_BURST_FIXED;
      write_q  <= 1'b0;
      beat_cnt <= '0;
`ifdef CBUS_WAIT_STATE_EN
      wait_cnt <= '0;
`endif
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (creq.valid) begin
            addr_q   <= {creq.addr[63:3], 3'b000};
            len_q    <= creq.len;
            burst_q  <= creq.burst;
            write_q  <= creq.is_write;
            beat_cnt <= '0;
`ifdef CBUS_WAIT_STATE_EN
            wait_cnt <= '0;
`endif
          end
        end
`ifdef CBUS_WAIT_STATE_EN
        WAIT: wait_cnt <= wait_cnt + 32'd1;
`endif
        BURST: begin
          beat_cnt <= beat_cnt + 4'd1;
          addr_q   <= next_addr;
        end
        default: ;
      endcase
    end
  end

  // Next-state logic; valid is only looked at while idle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (creq.valid) state_d = FIRST_STATE;
`ifdef CBUS_WAIT_STATE_EN
      WAIT:  if (wait_done) state_d = BURST;
`endif
      BURST: if (last_beat) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Response is purely a function of state so it drops the instant reset hits.
  always_comb begin
    cresp = '0;
    if (state_q == BURST) begin
      cresp.ready = 1'b1;
      cresp.last  = last_beat;
      if (!write_q && in_range) cresp.data = mem[word_idx];
    end
  end

  // SRAM write port: no reset, contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (state_q == BURST && write_q && in_range) begin
      for (int i = 0; i < CBUS_BEAT_BYTES; i++) begin
        if (creq.strobe[i]) mem[word_idx][8*i +: 8] <= creq.data[8*i +: 8];
      end
    end
  end

endmodule
